// File: rtl/trade_report_decoder.sv
// Receive-side decoder for the 5-byte trade report frame:
//   HEADER, trade action, profit[15:8], profit[7:0], FOOTER.
// Validates framing, enforces an inter-byte timeout inside a frame,
// presents decoded trade/profit with a one-cycle valid pulse and keeps
// saturating report/error counters. All outputs are registered.
module trade_report_decoder #(
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter logic [7:0]  FOOTER         = 8'h55,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       trade_action,
  output logic [15:0]      profit,
  output logic             report_valid,
  output logic             frame_error,
  output logic [CNT_W-1:0] report_count,
  output logic [CNT_W-1:0] error_count
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  // The timeout fires on the idle cycle in which the counter would step
  // onto TIMEOUT_CYCLES-1, so the frame is abandoned after
  // TIMEOUT_CYCLES-1 consecutive idle cycles.
  localparam logic [TO_W-1:0] TO_FIRE = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    WAIT_HEADER,
    GET_TRADE,
    GET_PHI,
    GET_PLO,
    GET_FOOTER
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]      sh_trade;
  logic [7:0]      sh_phi;
  logic [7:0]      sh_plo;

  // Frame FSM, timeout counter, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_HEADER;
      to_cnt       <= '0;
      sh_trade     <= '0;
      sh_phi       <= '0;
      sh_plo       <= '0;
      trade_action <= '0;
      profit       <= '0;
      report_valid <= 1'b0;
      frame_error  <= 1'b0;
      report_count <= '0;
      error_count  <= '0;
    end else begin
      report_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (state == WAIT_HEADER || rx_valid) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_FIRE) begin
        to_cnt      <= '0;
        state       <= WAIT_HEADER;
        frame_error <= 1'b1;
        if (error_count != '1) error_count <= error_count + 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (rx_valid) begin
        case (state)
          WAIT_HEADER: begin
            if (rx_data == HEADER) state <= GET_TRADE;
          end
          GET_TRADE: begin
            if (rx_data == 8'h01 || rx_data == 8'h02) begin
              sh_trade <= rx_data;
              state    <= GET_PHI;
            end else begin
              frame_error <= 1'b1;
              if (error_count != '1) error_count <= error_count + 1'b1;
              state <= (rx_data == HEADER) ? GET_TRADE : WAIT_HEADER;
            end
          end
          GET_PHI: begin
            sh_phi <= rx_data;
            state  <= GET_PLO;
          end
          GET_PLO: begin
            sh_plo <= rx_data;
            state  <= GET_FOOTER;
          end
          GET_FOOTER: begin
            if (rx_data == FOOTER) begin
              trade_action <= sh_trade;
              profit       <= {sh_phi, sh_plo};
              report_valid <= 1'b1;
              if (report_count != '1) report_count <= report_count + 1'b1;
              state <= WAIT_HEADER;
            end else begin
              frame_error <= 1'b1;
              if (error_count != '1) error_count <= error_count + 1'b1;
              state <= (rx_data == HEADER) ? GET_TRADE : WAIT_HEADER;
            end
          end
          default: state <= WAIT_HEADER;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trade_report_decoder.sv
// Directed bench for trade_report_decoder: short timeout and narrow
// counters so timeout and saturation are reachable quickly.
module tb_trade_report_decoder;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    trade_action;
  logic [15:0]   profit;
  logic          report_valid;
  logic          frame_error;
  logic [CW-1:0] report_count;
  logic [CW-1:0] error_count;

  int checks = 0;
  int errors = 0;

  trade_report_decoder #(
    .HEADER(8'hAA),
    .FOOTER(8'h55),
    .TIMEOUT_CYCLES(16),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .trade_action(trade_action),
    .profit(profit),
    .report_valid(report_valid),
    .frame_error(frame_error),
    .report_count(report_count),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] t, input logic [15:0] p,
                           input logic rv, input logic fe,
                           input logic [CW-1:0] rc, input logic [CW-1:0] ec);
    check({tag, ".trade"}, 32'(trade_action), 32'(t));
    check({tag, ".profit"}, 32'(profit), 32'(p));
    check({tag, ".rv"}, 32'(report_valid), 32'(rv));
    check({tag, ".fe"}, 32'(frame_error), 32'(fe));
    check({tag, ".rcnt"}, 32'(report_count), 32'(rc));
    check({tag, ".ecnt"}, 32'(error_count), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check_all("reset", 8'h00, 16'h0000, 0, 0, 0, 0);

    // Single valid frame
    send(8'hAA); send(8'h01); send(8'h12); send(8'h34);
    check("pre_footer.rv", 32'(report_valid), 0);
    send(8'h55);
    check_all("frame1", 8'h01, 16'h1234, 1, 0, 1, 0);
    idle(1);
    check("frame1.rv_pulse", 32'(report_valid), 0);

    // Back-to-back frames with consecutive strobes
    do_reset();
    send(8'hAA); send(8'h02); send(8'hFF); send(8'hFF); send(8'h55);
    check_all("b2b_a", 8'h02, 16'hFFFF, 1, 0, 1, 0);
    send(8'hAA);
    check("b2b_gap.rv", 32'(report_valid), 0);
    send(8'h01); send(8'h00); send(8'h07); send(8'h55);
    check_all("b2b_b", 8'h01, 16'h0007, 1, 0, 2, 0);

    // Bad footer which is a header: resync into the next frame
    do_reset();
    send(8'hAA); send(8'h01); send(8'h00); send(8'h10); send(8'hAA);
    check_all("badftr", 8'h00, 16'h0000, 0, 1, 0, 1);
    send(8'h02);
    check("badftr.fe_pulse", 32'(frame_error), 0);
    send(8'h00); send(8'h20); send(8'h55);
    check_all("resync", 8'h02, 16'h0020, 1, 0, 1, 1);

    // Garbage in WAIT_HEADER, then bad trade code 00
    do_reset();
    send(8'hAA); send(8'h01); send(8'h12); send(8'h34); send(8'h55);
    send(8'h13); send(8'h77);
    check_all("garbage", 8'h01, 16'h1234, 0, 0, 1, 0);
    send(8'hAA); send(8'h00);
    check_all("badtrade", 8'h01, 16'h1234, 0, 1, 1, 1);
    // After the error the FSM waits for a header: 02 is ignored
    send(8'h02); send(8'h02);
    check("badtrade.idle_ecnt", 32'(error_count), 1);

    // Timeout: 15 idle cycles abandon the frame
    do_reset();
    send(8'hAA); send(8'h01);
    idle(14);
    check("to.before", 32'(frame_error), 0);
    idle(1);
    check_all("to.fire", 8'h00, 16'h0000, 0, 1, 0, 1);
    idle(1);
    check("to.pulse", 32'(frame_error), 0);
    send(8'hAA); send(8'h02); send(8'h00); send(8'h05); send(8'h55);
    check_all("to.after", 8'h02, 16'h0005, 1, 0, 1, 1);

    // Byte arriving on the cycle the timeout would fire wins
    do_reset();
    send(8'hAA); send(8'h01);
    idle(14);
    send(8'h12);
    check("to.race_fe", 32'(frame_error), 0);
    idle(14);
    send(8'h34);
    send(8'h55);
    check_all("to.race", 8'h01, 16'h1234, 1, 0, 1, 0);

    // Reset mid-frame, together with a strobe
    send(8'hAA); send(8'h01); send(8'h12);
    rst = 1'b1; rx_data = 8'h34; rx_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    check_all("midrst", 8'h00, 16'h0000, 0, 0, 0, 0);
    send(8'hAA); send(8'h01); send(8'h00); send(8'h01); send(8'h55);
    check_all("postrst", 8'h01, 16'h0001, 1, 0, 1, 0);

    // Error counter saturates at all-ones (CNT_W=2 -> 3)
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'hAA); send(8'h03);
    end
    check("sat.ecnt", 32'(error_count), 3);
    for (int i = 0; i < 4; i++) begin
      send(8'hAA); send(8'h01); send(8'h00); send(8'h00); send(8'h55);
    end
    check("sat.rcnt", 32'(report_count), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
